// File: rtl/ierdna_sched.sv
// ierdna_sched: round-robin scheduler sharing one 1-bit ierdna datapath
// among NREQ (2..4) requesters.
//
// The winning requester's operands are latched in IDLE. KICK drives
// ide/icul complemented so the edge-sensitive datapath is forced to see a
// transition. APPLY drives the real values and captures the results, and
// RESP presents them with the requester tag.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req[NREQ]                  per-requester request
//   op[4*NREQ]                 operands, requester i at op[4i+3:4i] = {aral, atac, ide, icul}
//   gnt[NREQ]                  one-hot, one-cycle grant pulse (KICK cycle)
//   busy                       high in KICK/APPLY/RESP
//   rsp_valid                  one-cycle result strobe
//   rsp_id                     index of the requester being answered
//   rsp_data                   {anao, anaid, luap}
//   rsp_err                    divide-by-zero case (aral=0, icul=0)
//   rsp_mis                    captured result disagrees with the golden model
//   dp_aral..dp_icul           registered drive to the datapath
//   dp_anao, dp_anaid, dp_luap datapath results
module ierdna_sched #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] op,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [2:0]        rsp_data,
    output logic              rsp_err,
    output logic              rsp_mis,
    output logic              dp_aral,
    output logic              dp_atac,
    output logic              dp_ide,
    output logic              dp_icul,
    input  logic              dp_anao,
    input  logic              dp_anaid,
    input  logic              dp_luap
);

    typedef enum logic [1:0] {IDLE, KICK, APPLY, RESP} state_t;

    // Golden model over the latched operand nibble {aral, atac, ide, icul}.
    function automatic logic gold_anao(input logic [3:0] n);
        return n[3] ? (n[1] ^ n[2]) : (n[0] ^ n[2]);
    endfunction

    function automatic logic gold_anaid(input logic [3:0] n);
        return n[0] ? n[2] : 1'b0;
    endfunction

    function automatic logic gold_luap(input logic [3:0] n);
        return ^n;
    endfunction

    function automatic logic is_div0(input logic [3:0] n);
        return ~n[3] & ~n[0];
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        win_q, win_d;
    logic [3:0]        opl_q, opl_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_id_q, rsp_id_d;
    logic [2:0]        rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic              dp_aral_q, dp_aral_d;
    logic              dp_atac_q, dp_atac_d;
    logic              dp_ide_q, dp_ide_d;
    logic              dp_icul_q, dp_icul_d;

    // Requests and operands are widened to the 4-requester maximum so the
    // arbiter can index them with a plain 2-bit requester number.
    logic [3:0]        req_ext;
    logic [15:0]       op_ext;
    logic [3:0]        gnt_ext;
    logic [2:0]        idx;
    logic [1:0]        win;
    logic              found;
    logic [3:0]        sel_op;
    logic              err;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        opl_d       = opl_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_mis_d   = rsp_mis_q;
        dp_aral_d   = dp_aral_q;
        dp_atac_d   = dp_atac_q;
        dp_ide_d    = dp_ide_q;
        dp_icul_d   = dp_icul_q;

        req_ext = '0;
        req_ext[NREQ-1:0] = req;
        op_ext = '0;
        op_ext[4*NREQ-1:0] = op;

        // First pending requester at or after ptr, wrapping at NREQ-1.
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'(NREQ)) begin
                idx = idx - 3'(NREQ);
            end
            if (!found && req_ext[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
        sel_op  = op_ext[{win, 2'b00} +: 4];
        gnt_ext = '0;
        gnt_ext[win] = 1'b1;

        err = is_div0(opl_q);

        case (state_q)
            IDLE: begin
                if (found) begin
                    opl_d     = sel_op;
                    win_d     = win;
                    ptr_d     = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
                    gnt_d     = gnt_ext[NREQ-1:0];
                    busy_d    = 1'b1;
                    // ide/icul start inverted to force an edge into the datapath.
                    dp_aral_d = sel_op[3];
                    dp_atac_d = sel_op[2];
                    dp_ide_d  = ~sel_op[1];
                    dp_icul_d = ~sel_op[0];
                    state_d   = KICK;
                end
            end
            KICK: begin
                dp_ide_d  = opl_q[1];
                dp_icul_d = opl_q[0];
                state_d   = APPLY;
            end
            APPLY: begin
                // anaid is undefined in the divide-by-zero case: forced to 0
                // and excluded from the self-check.
                rsp_data_d  = {dp_anao, dp_anaid & ~err, dp_luap};
                rsp_err_d   = err;
                rsp_mis_d   = (dp_anao != gold_anao(opl_q)) |
                              (dp_luap != gold_luap(opl_q)) |
                              (~err & (dp_anaid != gold_anaid(opl_q)));
                rsp_id_d    = win_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            opl_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            dp_aral_q   <= 1'b0;
            dp_atac_q   <= 1'b0;
            dp_ide_q    <= 1'b0;
            dp_icul_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            opl_q       <= opl_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            dp_aral_q   <= dp_aral_d;
            dp_atac_q   <= dp_atac_d;
            dp_ide_q    <= dp_ide_d;
            dp_icul_q   <= dp_icul_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_mis   = rsp_mis_q;
    assign dp_aral   = dp_aral_q;
    assign dp_atac   = dp_atac_q;
    assign dp_ide    = dp_ide_q;
    assign dp_icul   = dp_icul_q;

endmodule

// File: doc/ierdna_sched.md
# ierdna_sched

Round-robin scheduler that shares one `ierdna` 1-bit arithmetic datapath between up to four requesters. It arbitrates among the requesters, then drives the selected operand set onto the datapath. The `ierdna` evaluation block is sensitive only to `ide`/`icul`, so the scheduler forces an edge on those inputs before applying the real values. It then captures the three results and returns them with a requester tag, a divide-by-zero flag and a self-check flag.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..4.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  request per requester; held high until its `gnt` is seen.
- `op`  in  4*NREQ  operands, requester i at `op[4i+3:4i]` = {aral, atac, ide, icul}.
- `gnt`  out  NREQ  one-hot, one-cycle grant pulse.
- `busy`  out  1  high while a transaction is in flight.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_id`  out  2  index of the requester being answered.
- `rsp_data`  out  3  {anao, anaid, luap}.
- `rsp_err`  out  1  divide-by-zero case (aral=0, icul=0).
- `rsp_mis`  out  1  captured result differs from the internal golden model.
- `dp_aral`, `dp_atac`, `dp_ide`, `dp_icul`  out  1 each  registered drive to the datapath.
- `dp_anao`, `dp_anaid`, `dp_luap`  in  1 each  datapath results.

## Operation
- **FSM states:** IDLE, KICK, APPLY, RESP.
- **IDLE:** if any `req` bit is high, choose the first requester at or after `ptr`, scanning upward with wrap at NREQ-1 → 0.
  - Latch that requester's `op` and index.
  - Set `ptr` ← winner+1 mod NREQ.
  - Go to KICK.
  - If no request is pending, stay in IDLE.
- **KICK:** `gnt[winner]`=1.
  - `dp_aral`/`dp_atac` = latched values.
  - `dp_ide`/`dp_icul` = complement of latched values.
  - Always go to APPLY.
- **APPLY:** all `dp_*` = latched values.
  - At the end of the cycle, capture `dp_anao`/`dp_anaid`/`dp_luap` into the response registers.
  - Go to RESP.
- **RESP:** `rsp_valid`=1 with the captured data; go to IDLE. `dp_*` hold their APPLY values until the next KICK.
- **Golden model**, computed from the latched operands (1-bit arithmetic, truncated):
  - anao = aral ? ide^atac : icul^atac
  - anaid = icul ? atac : 0
  - luap = aral^atac^ide^icul
- **rsp_err:** `rsp_err`=1 iff aral=0 and icul=0. In that case `rsp_data[1]` is forced to 0 and `dp_anaid` is ignored, because it is undefined.
- **rsp_mis:** `rsp_mis`=1 iff any non-ignored captured bit differs from the golden model.
- `rsp_id`, `rsp_data`, `rsp_err` and `rsp_mis` hold their values until the next RESP.
- `busy`=1 in KICK, APPLY and RESP.
- Requests arriving while busy are not lost. They are evaluated at the next IDLE.
- A requester that drops `req` before being granted is simply skipped.

## Timing
- **Reset:** all outputs 0, `ptr`=0, state IDLE, latched operands 0.
- **Reset mid-transaction** (any state): state returns to IDLE on the next edge and no `rsp_valid` is issued. The aborted requester receives no response and must re-request.
- **Cycle sequence** (cycle n = IDLE with a request sampled):
  - n+1: KICK, `gnt`
  - n+2: APPLY
  - n+3: RESP, `rsp_valid`
  - n+4: IDLE again
- Earliest back-to-back `gnt` spacing is 4 cycles. Latency from request to `rsp_valid` is 3 cycles.
- `op` is sampled only in the IDLE cycle that wins arbitration. Changes to `op` afterwards do not affect the transaction.
- The requester may deassert `req` in the cycle after `gnt`. If `req` is still high at the next IDLE, it is treated as a new request.
- Simultaneous requests are served strictly round-robin. No requester waits more than NREQ-1 transactions.

## Test plan
- **Single request.** Reset, then `req`=01, `op[3:0]`=0011.
  - `gnt`=01 at n+1, with `dp_ide`/`dp_icul`=0/0.
  - At n+2, `dp_ide`/`dp_icul`=1/1.
  - At n+3, `rsp_valid`=1, `rsp_id`=0, `rsp_data`=100, `rsp_err`=0, `rsp_mis`=0.
- **Contention.** `req`=11 held continuously, NREQ=2.
  - Grant order 0,1,0,1, with `gnt` pulses 4 cycles apart.
  - `rsp_id` follows the same order.
- **Divide-by-zero.** `op`=0100.
  - `rsp_err`=1, `rsp_data`=101.
  - `rsp_mis`=0 even when the bench drives `dp_anaid`=X.
- **aral=1, icul=0.** `op`=1110 → `rsp_data`=001, `rsp_err`=0.
- **Reset mid-transaction.** Pull `rst_n`=0 during APPLY.
  - No `rsp_valid`.
  - All outputs 0 on the next cycle.
  - A subsequent `req`=11 is granted to requester 0 first.
- **Self-check.** The bench inverts `dp_luap` for `op`=0011 → `rsp_data`=101, `rsp_mis`=1.
